// File: rtl/watch_pkg.sv
// -----------------------------------------------------------------------------
// watch_pkg
// Shared constants for the MM:SS watch: the set-mode state encoding seen on
// set_mode, and the BCD digit limits used by both the time-setting front end
// and the watch counter.
// -----------------------------------------------------------------------------
package watch_pkg;

    // set_mode / FSM state encoding
    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_SET_MIN = 2'd1;
    localparam logic [1:0] ST_SET_SEC = 2'd2;

    // Largest legal tens digit (5x) and ones digit (x9) of a minutes/seconds field
    localparam logic [3:0] TEN_MAX = 4'd5;
    localparam logic [3:0] ONE_MAX = 4'd9;

    typedef struct packed {
        logic [3:0] m_ten;
        logic [3:0] m_one;
        logic [3:0] s_ten;
        logic [3:0] s_one;
    } bcd_time_t;

endpackage

// File: rtl/watch_set_ctrl_if.sv
// -----------------------------------------------------------------------------
// watch_set_ctrl_if
// Bundle between the time-setting front end and its surroundings (buttons,
// watch counter, display).
//   btn_mode, btn_up        raw active-high push buttons
//   cur_*                   live BCD time from the counter
//   load, ld_*              one-cycle load strobe and the digits to load
//   run_en                  counter advance enable
//   set_mode                0 RUN, 1 SET_MIN, 2 SET_SEC
//   blink_on                edited field visible (1) / blanked (0)
// master: the watch_set_ctrl side.  slave: buttons/counter/display side.
// -----------------------------------------------------------------------------
interface watch_set_ctrl_if;

    logic       btn_mode;
    logic       btn_up;
    logic [3:0] cur_m_ten;
    logic [3:0] cur_m_one;
    logic [3:0] cur_s_ten;
    logic [3:0] cur_s_one;
    logic       load;
    logic [3:0] ld_m_ten;
    logic [3:0] ld_m_one;
    logic [3:0] ld_s_ten;
    logic [3:0] ld_s_one;
    logic       run_en;
    logic [1:0] set_mode;
    logic       blink_on;

    modport master (
        input  btn_mode, btn_up,
        input  cur_m_ten, cur_m_one, cur_s_ten, cur_s_one,
        output load,
        output ld_m_ten, ld_m_one, ld_s_ten, ld_s_one,
        output run_en, set_mode, blink_on
    );

    modport slave (
        output btn_mode, btn_up,
        output cur_m_ten, cur_m_one, cur_s_ten, cur_s_one,
        input  load,
        input  ld_m_ten, ld_m_one, ld_s_ten, ld_s_one,
        input  run_en, set_mode, blink_on
    );

endinterface

// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// Synchronizes one raw button, accepts a level change only after it has been
// stable for DEBOUNCE_MS cycles, and emits a one-cycle press pulse on each
// accepted 0->1 change.
//   clk, rst   clock, asynchronous active-high reset
//   btn_raw    raw button, asynchronous to clk
//   level      debounced level
//   press      one-cycle pulse, one cycle after level rises
// -----------------------------------------------------------------------------
module btn_debounce #(
    parameter int DEBOUNCE_MS = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic level,
    output logic press
);

    localparam int            CW       = $clog2(DEBOUNCE_MS + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_MS - 1);

    logic          sync_p0;
    logic          sync_p1;
    logic [CW-1:0] cnt;
    logic          level_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            cnt     <= '0;
            level   <= 1'b0;
            level_d <= 1'b0;
            press   <= 1'b0;
        end else begin
            // stage p0/p1: two-flop synchronizer
            sync_p0 <= btn_raw;
            sync_p1 <= sync_p0;

            // stable-difference counter; any agreement restarts it
            if (sync_p1 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt   <= '0;
                level <= sync_p1;
            end else begin
                cnt <= cnt + CW'(1);
            end

            // rising edge of the debounced level
            level_d <= level;
            press   <= level & ~level_d;
        end
    end

endmodule

// File: rtl/watch_set_ctrl.sv
// -----------------------------------------------------------------------------
// watch_set_ctrl
// Time-setting front end for the MM:SS watch counter. Debounces mode/up,
// auto-repeats a held up button, steps RUN -> SET_MIN -> SET_SEC -> RUN,
// edits the BCD time, loads it into the counter on leaving SET_SEC, and
// produces a blink flag for the field being edited.
//   clk, rst   1 kHz clock, asynchronous active-high reset
//   bus        watch_set_ctrl_if.master (buttons, cur_*, load, ld_*, run_en,
//              set_mode, blink_on); all outputs are registered
// -----------------------------------------------------------------------------
module watch_set_ctrl
    import watch_pkg::*;
#(
    parameter int DEBOUNCE_MS = 20,
    parameter int REPEAT_DLY  = 600,
    parameter int REPEAT_PER  = 200,
    parameter int BLINK_HALF  = 500
) (
    input  logic             clk,
    input  logic             rst,
    watch_set_ctrl_if.master bus
);

    localparam int            HW         = $clog2(REPEAT_DLY + 1);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(REPEAT_DLY - 1);
    localparam int            PW         = $clog2(REPEAT_PER + 1);
    localparam logic [PW-1:0] PER_LAST   = PW'(REPEAT_PER - 1);
    localparam int            BW         = $clog2(BLINK_HALF + 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

    logic          mode_level, mode_press;
    logic          up_level, up_press;
    logic [HW-1:0] hold_cnt;
    logic [PW-1:0] per_cnt;
    logic          rep_p;
    logic          up_evt;
    logic [1:0]    state;
    bcd_time_t     edit;
    bcd_time_t     ld_r;
    logic          load_r;
    logic          run_en_r;
    logic          blink_r;
    logic [BW-1:0] blink_cnt;

    // +1 on a two-digit BCD field with 59 -> 00 wrap
    function automatic logic [7:0] bcd_inc(input logic [3:0] ten, input logic [3:0] one);
        logic [7:0] r;
        if (one == ONE_MAX) begin
            r = (ten == TEN_MAX) ? 8'h00 : {ten + 4'd1, 4'd0};
        end else begin
            r = {ten, one + 4'd1};
        end
        return r;
    endfunction

    btn_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_db_mode (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (bus.btn_mode),
        .level   (mode_level),
        .press   (mode_press)
    );

    btn_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_db_up (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (bus.btn_up),
        .level   (up_level),
        .press   (up_press)
    );

    // Auto-repeat: hold_cnt measures time since the debounced rise, then
    // per_cnt paces repeats; its zero phase marks each repeat. Holding mode
    // pauses repeat so a long two-button hold cannot race through values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt <= '0;
            per_cnt  <= '0;
            rep_p    <= 1'b0;
        end else if (!up_level || mode_level || state == ST_RUN) begin
            hold_cnt <= '0;
            per_cnt  <= '0;
            rep_p    <= 1'b0;
        end else if (hold_cnt != HOLD_LAST) begin
            hold_cnt <= hold_cnt + HW'(1);
            rep_p    <= 1'b0;
        end else begin
            rep_p   <= (per_cnt == '0);
            per_cnt <= (per_cnt == PER_LAST) ? '0 : per_cnt + PW'(1);
        end
    end

    assign up_evt = up_press | rep_p;

    // FSM, edit registers, load/run outputs and blink
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_RUN;
            edit      <= '0;
            ld_r      <= '0;
            load_r    <= 1'b0;
            run_en_r  <= 1'b1;
            blink_r   <= 1'b1;
            blink_cnt <= '0;
        end else begin
            load_r <= 1'b0;
            if (mode_press) begin
                // mode has priority; a coincident up event is dropped
                blink_cnt <= '0;
                blink_r   <= 1'b1;
                case (state)
                    ST_RUN: begin
                        edit     <= '{bus.cur_m_ten, bus.cur_m_one, bus.cur_s_ten, bus.cur_s_one};
                        state    <= ST_SET_MIN;
                        run_en_r <= 1'b0;
                    end
                    ST_SET_MIN: begin
                        state <= ST_SET_SEC;
                    end
                    default: begin
                        state    <= ST_RUN;
                        load_r   <= 1'b1;
                        ld_r     <= edit;
                        run_en_r <= 1'b1;
                    end
                endcase
            end else if (up_evt && state != ST_RUN) begin
                blink_cnt <= '0;
                blink_r   <= 1'b1;
                if (state == ST_SET_MIN) begin
                    {edit.m_ten, edit.m_one} <= bcd_inc(edit.m_ten, edit.m_one);
                end else begin
                    {edit.s_ten, edit.s_one} <= bcd_inc(edit.s_ten, edit.s_one);
                end
            end else if (state != ST_RUN) begin
                if (blink_cnt == BLINK_LAST) begin
                    blink_cnt <= '0;
                    blink_r   <= ~blink_r;
                end else begin
                    blink_cnt <= blink_cnt + BW'(1);
                end
            end else begin
                blink_cnt <= '0;
                blink_r   <= 1'b1;
            end
        end
    end

    assign bus.load     = load_r;
    assign bus.ld_m_ten = ld_r.m_ten;
    assign bus.ld_m_one = ld_r.m_one;
    assign bus.ld_s_ten = ld_r.s_ten;
    assign bus.ld_s_one = ld_r.s_one;
    assign bus.run_en   = run_en_r;
    assign bus.set_mode = state;
    assign bus.blink_on = blink_r;

endmodule

// File: doc/watch_set_ctrl.md
# watch_set_ctrl

Time-setting front end for the 1 kHz MM:SS watch counter. Debounces the two raw push buttons (mode, up), runs a RUN / SET_MIN / SET_SEC state machine, and hands the counter a one-cycle load strobe with new BCD digits plus a run enable. It also provides a blink flag that the display stage uses to flash the field being edited.

## Interface
Parameters:
- DEBOUNCE_MS, 20: consecutive stable cycles (1 ms each) needed to accept a button level change.
- REPEAT_DLY, 600: cycles `up` must be held before auto-repeat starts.
- REPEAT_PER, 200: cycles between auto-repeat increments.
- BLINK_HALF, 500: cycles per blink half-period.

Ports:
- clk  in  1  1 kHz system clock.
- rst  in  1  Asynchronous, active-high reset.
- btn_mode  in  1  Raw mode button, active-high, asynchronous to clk.
- btn_up  in  1  Raw increment button, active-high, asynchronous to clk.
- cur_m_ten, cur_m_one, cur_s_ten, cur_s_one  in  4 each  Live BCD time from the watch counter.
- load  out  1  One-cycle strobe: counter takes ld_* digits and clears its ms prescaler.
- ld_m_ten, ld_m_one, ld_s_ten, ld_s_one  out  4 each  Edited BCD digits.
- run_en  out  1  1 = counter advances; 0 = counter frozen.
- set_mode  out  2  0 = RUN, 1 = SET_MIN, 2 = SET_SEC.
- blink_on  out  1  1 = edited field visible, 0 = blanked.

## Operation
- Every output is registered. Reset values:
  - load = 0, all ld_* = 0, run_en = 1, set_mode = 0, blink_on = 1.
  - State = RUN, edit registers = 0, debouncers idle low.
- Debounce, per button:
  - Input passes through a 2-FF synchronizer.
  - A counter clears whenever the synchronized level equals the debounced level.
  - When the levels have differed for DEBOUNCE_MS consecutive cycles, the debounced level flips.
  - A 0→1 flip produces a one-cycle `press` pulse.
- Auto-repeat (up only):
  - While debounced up stays high in SET_MIN or SET_SEC, a hold counter runs.
  - It emits an extra `press` at REPEAT_DLY cycles after the initial press, then every REPEAT_PER cycles.
  - It clears on release.
- State machine:
  - **RUN:**
    - mode press → copy cur_* into the edit registers, go to SET_MIN, run_en = 0.
    - up press is ignored.
  - **SET_MIN:**
    - up press → minutes +1 in BCD: one digit 9→0 with ten +1; 59→00.
    - mode press → SET_SEC.
  - **SET_SEC:**
    - up press → seconds +1, same BCD rule, 59→00. Minutes are never touched.
    - mode press → RUN. In the same registered update: load = 1 for one cycle, ld_* = edit registers, run_en = 1.
- Simultaneous mode and up press in one cycle: mode wins, up is discarded.
- ld_* hold their last loaded value outside load cycles.
- Blink:
  - In SET_MIN / SET_SEC, blink_on toggles every BLINK_HALF cycles.
  - On every state entry the blink counter restarts with blink_on = 1.
  - An up press also restarts it with blink_on = 1, so the new value is visible immediately.
  - In RUN, blink_on = 1.
- Reset mid-edit: return to RUN, no load pulse; the edited value is discarded.

## Timing
- Raw edge to debounced flip: 2 sync cycles + DEBOUNCE_MS cycles.
- `press` lands 1 cycle later; the FSM, edit register and output update 1 cycle after that.
- Worst case raw edge to visible output change: DEBOUNCE_MS + 4 cycles.
- Glitches shorter than DEBOUNCE_MS cycles never produce a press.
- load is exactly 1 cycle wide. The counter samples it on the next clk edge, and counting resumes from the loaded value with a fresh 1000-cycle second.
- Release debounce is symmetric; release produces no pulse.

## Structure
- Shared package watch_pkg:
  - State encoding constants ST_RUN = 2'd0, ST_SET_MIN = 2'd1, ST_SET_SEC = 2'd2.
  - BCD limits TEN_MAX = 4'd5 and ONE_MAX = 4'd9, also used by the counter.
- Sub-module btn_debounce:
  - Contents: synchronizer, debounce counter, press pulse.
  - Parameter: DEBOUNCE_MS.
  - Instantiated twice.
- Auto-repeat, FSM, BCD increment and blink live in the top.

## Test plan
- Reset check: assert rst mid-SET_SEC → next cycle set_mode = 0, run_en = 1, load = 0, blink_on = 1.
- Glitch rejection: btn_mode high for 15 cycles then low → no state change. High for 25 cycles → set_mode = 1 at cycle 24 after the raw edge, run_en = 0.
- Minute wrap: cur time 58:30, enter SET_MIN, two up presses → edit minutes = 00, seconds still 30. Two further mode presses → load pulse with ld = 0,0,3,0.
- Second digit carry and wrap: in SET_SEC from 12:09, one up press → 12:10. From 12:59, one up press → 12:00 with m_one unchanged.
- Auto-repeat: hold up 1000 cycles in SET_MIN from 00 → exactly 1 + 3 increments (at press, +600, +800, +1000) → minutes = 04.
- Mode/up collision: mode and up presses in the same cycle in SET_MIN → SET_SEC with minutes unchanged. blink_on toggles at 500 and 1000 cycles after entry.
